// File: rtl/display_driver_if.sv
// Bundles the command/data inputs and segment/digit outputs of the
// multiplexed 7-segment display driver.
//   i_comm [10:0]      : {brightness[2:0], enable mask[3:0], blink mask[3:0]}
//   i_data [SIZE*8-1:0]: byte d is the raw segment pattern of digit d
//   o_seg  [7:0]       : shared segment bus, active-high (bit 7 = dp)
//   o_dig  [SIZE-1:0]  : digit select, one-hot or all-zero, active-high
// master = clock/menu logic side, slave = the display driver.
interface display_driver_if #(
  parameter int SIZE = 4
);
  logic [10:0]         i_comm;
  logic [SIZE*8-1:0]   i_data;
  logic [7:0]          o_seg;
  logic [SIZE-1:0]     o_dig;

  modport master (
    output i_comm,
    output i_data,
    input  o_seg,
    input  o_dig
  );

  modport slave (
    input  i_comm,
    input  i_data,
    output o_seg,
    output o_dig
  );
endinterface

// File: rtl/display_driver.sv
// Multiplexed 7-segment display driver.
// Scans SIZE digits in order 0..SIZE-1. Each digit slot is 8 PWM sub-steps
// of TICK clocks each; a digit is lit on sub-steps s <= brightness, when its
// enable bit is set, and when it is not in the dark half of its blink phase.
// Inputs are used unlatched; outputs are registered (1-cycle latency).
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset (clears counters and outputs)
//   bus     : display_driver_if slave modport (i_comm, i_data, o_seg, o_dig)
module display_driver #(
  parameter int SIZE       = 4,
  parameter int TICK       = 1,
  parameter int BLINK_LOG2 = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  display_driver_if.slave  bus
);

  localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int DW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [TW-1:0]         t_q, t_d;
  logic [2:0]            s_q, s_d;
  logic [DW-1:0]         d_q, d_d;
  logic [BLINK_LOG2:0]   c_q, c_d;
  logic [7:0]            seg_q, seg_d;
  logic [SIZE-1:0]       dig_q, dig_d;

  logic [3:0]            en_mask;
  logic [3:0]            blink_mask;
  logic [2:0]            bright;
  logic                  lit;

  // Per-digit segment bytes, unpacked for readable selection.
  logic [7:0]            digit_byte [SIZE];

  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_bytes
      assign digit_byte[gi] = bus.i_data[gi*8 +: 8];
    end
  endgenerate

  assign bright     = bus.i_comm[10:8];
  assign en_mask    = bus.i_comm[7:4];
  assign blink_mask = bus.i_comm[3:0];

  // Mask bits at or above SIZE are never selected because d_q < SIZE.
  assign lit = en_mask[d_q]
             & ~(blink_mask[d_q] & c_q[BLINK_LOG2])
             & (s_q <= bright);

  // Scan counters: t rolls into s, s rolls into d.
  always_comb begin
    t_d = t_q + 1'b1;
    s_d = s_q;
    d_d = d_q;
    c_d = c_q + 1'b1;
    if (t_q == TW'(TICK - 1)) begin
      t_d = '0;
      s_d = s_q + 3'd1;
      if (s_q == 3'd7) begin
        if (d_q == DW'(SIZE - 1)) begin
          d_d = '0;
        end else begin
          d_d = d_q + 1'b1;
        end
      end
    end
  end

  // Output image computed from the pre-increment scan position.
  always_comb begin
    seg_d = '0;
    dig_d = '0;
    if (lit) begin
      seg_d = digit_byte[d_q];
      dig_d = SIZE'(1) << d_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      t_q   <= '0;
      s_q   <= '0;
      d_q   <= '0;
      c_q   <= '0;
      seg_q <= '0;
      dig_q <= '0;
    end else begin
      t_q   <= t_d;
      s_q   <= s_d;
      d_q   <= d_d;
      c_q   <= c_d;
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign bus.o_seg = seg_q;
  assign bus.o_dig = dig_q;

endmodule

// File: tb/tb_display_driver.sv
// Bench for display_driver: two instances (4 digits/TICK=1/blink bit 5 and
// 3 digits/TICK=2/blink bit 3) share command and data. An arithmetic model
// derives the scan position from the number of edges since reset release.
module tb_display_driver;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   edge_i;
  bit   armed;

  display_driver_if #(.SIZE(4)) bus_a ();
  display_driver_if #(.SIZE(3)) bus_b ();

  assign bus_b.i_comm = bus_a.i_comm;
  assign bus_b.i_data = bus_a.i_data[23:0];

  display_driver #(.SIZE(4), .TICK(1), .BLINK_LOG2(5)) dut_a (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus_a.slave)
  );

  display_driver #(.SIZE(3), .TICK(2), .BLINK_LOG2(3)) dut_b (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output expected after edge number k (counted from reset release).
  function automatic void model(input int k, input int size, input int tick,
                                input int bl, input logic [10:0] comm,
                                input logic [31:0] data,
                                output logic [7:0] seg, output logic [3:0] dig);
    int s, d;
    logic ph, lit;
    s   = (k / tick) % 8;
    d   = (k / (8 * tick)) % size;
    ph  = ((k >> bl) & 1) != 0;
    lit = comm[4 + d] && !(comm[d] && ph) && (s <= int'(comm[10:8]));
    seg = lit ? data[d*8 +: 8] : 8'h00;
    dig = lit ? (4'b0001 << d) : 4'b0000;
  endfunction

  int         k_mdl;
  logic [7:0] exp_a_seg, exp_b_seg;
  logic [3:0] exp_a_dig, exp_b_dig;

  always @(posedge clk or negedge rst_n) begin : mdl
    logic [7:0] sa, sb;
    logic [3:0] da, db;
    if (!rst_n) begin
      k_mdl     <= 0;
      exp_a_seg <= '0;
      exp_a_dig <= '0;
      exp_b_seg <= '0;
      exp_b_dig <= '0;
    end else begin
      model(k_mdl, 4, 1, 5, bus_a.i_comm, bus_a.i_data, sa, da);
      model(k_mdl, 3, 2, 3, bus_b.i_comm, {8'h00, bus_b.i_data}, sb, db);
      exp_a_seg <= sa;
      exp_a_dig <= da;
      exp_b_seg <= sb;
      exp_b_dig <= db;
      k_mdl     <= k_mdl + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("a_seg", {24'h0, bus_a.o_seg}, {24'h0, exp_a_seg});
      chk("a_dig", {28'h0, bus_a.o_dig}, {28'h0, exp_a_dig});
      chk("b_seg", {24'h0, bus_b.o_seg}, {24'h0, exp_b_seg});
      chk("b_dig", {28'h0, bus_b.o_dig}, {29'h0, exp_b_dig[2:0]});
      chk("a_onehot", {31'h0, ($countones(bus_a.o_dig) > 1)}, 32'h0);
    end
  end

  task automatic lit(input string name, input logic [3:0] edig, input logic [7:0] eseg);
    $display("edge %0d comm=%h: dig=%b seg=%h (want %b %h) [%s]",
             edge_i - 1, bus_a.i_comm, bus_a.o_dig, bus_a.o_seg, edig, eseg, name);
    chk({name, "_dig"}, {28'h0, bus_a.o_dig}, {28'h0, edig});
    chk({name, "_seg"}, {24'h0, bus_a.o_seg}, {24'h0, eseg});
  endtask

  task automatic release_rst();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    edge_i = 0;
    armed  = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    release_rst();
  endtask

  // Advance until the output of edge e is visible.
  task automatic run_to(input int e);
    while (edge_i <= e) begin
      @(posedge clk);
      #1 edge_i++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    armed  = 1'b0;
    edge_i = 0;
    rst_n  = 1'b0;
    bus_a.i_comm = 11'h7F0;
    bus_a.i_data = 32'h55AA_0FFF;
    #1;
    chk("reset_seg", {24'h0, bus_a.o_seg}, 32'h0);
    chk("reset_dig", {28'h0, bus_a.o_dig}, 32'h0);
    release_rst();

    // Full brightness scan
    run_to(0);  lit("full_e0",  4'b0001, 8'hFF);
    run_to(7);  lit("full_e7",  4'b0001, 8'hFF);
    run_to(8);  lit("full_e8",  4'b0010, 8'h0F);
    run_to(16); lit("full_e16", 4'b0100, 8'hAA);
    run_to(24); lit("full_e24", 4'b1000, 8'h55);
    run_to(32); lit("full_e32", 4'b0001, 8'hFF);

    // Brightness B=3, then B=0
    bus_a.i_comm = 11'h3F0;
    do_reset();
    run_to(3);  lit("b3_e3",  4'b0001, 8'hFF);
    run_to(4);  lit("b3_e4",  4'b0000, 8'h00);
    run_to(11); lit("b3_e11", 4'b0010, 8'h0F);
    run_to(12); lit("b3_e12", 4'b0000, 8'h00);
    run_to(31); lit("b3_e31", 4'b0000, 8'h00);
    bus_a.i_comm = 11'h0F0;
    do_reset();
    run_to(0);  lit("b0_e0", 4'b0001, 8'hFF);
    run_to(1);  lit("b0_e1", 4'b0000, 8'h00);
    run_to(8);  lit("b0_e8", 4'b0010, 8'h0F);
    run_to(9);  lit("b0_e9", 4'b0000, 8'h00);

    // Enable mask: digits 1 and 3 only
    bus_a.i_comm = 11'h7A0;
    do_reset();
    run_to(0);  lit("en_e0",  4'b0000, 8'h00);
    run_to(7);  lit("en_e7",  4'b0000, 8'h00);
    run_to(8);  lit("en_e8",  4'b0010, 8'h0F);
    run_to(16); lit("en_e16", 4'b0000, 8'h00);
    run_to(24); lit("en_e24", 4'b1000, 8'h55);

    // Blink on digit 1, phase from bit 5
    bus_a.i_comm = 11'h7F2;
    do_reset();
    run_to(8);  lit("bl_e8",  4'b0010, 8'h0F);
    run_to(32); lit("bl_e32", 4'b0001, 8'hFF);
    run_to(40); lit("bl_e40", 4'b0000, 8'h00);
    run_to(48); lit("bl_e48", 4'b0100, 8'hAA);
    run_to(72); lit("bl_e72", 4'b0010, 8'h0F);

    // Mid-slot data change and mid-scan reset
    bus_a.i_comm = 11'h7F0;
    do_reset();
    run_to(1);
    bus_a.i_data = 32'h55AA_0F00;
    run_to(2);  lit("chg_e2", 4'b0001, 8'h00);
    bus_a.i_data = 32'h55AA_0FFF;
    run_to(18); lit("pre_rst_e18", 4'b0100, 8'hAA);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", {24'h0, bus_a.o_seg}, 32'h0);
    chk("async_rst_dig", {28'h0, bus_a.o_dig}, 32'h0);
    chk("async_rst_b_dig", {29'h0, bus_b.o_dig}, 32'h0);
    release_rst();
    run_to(0);  lit("rel_e0", 4'b0001, 8'hFF);
    run_to(1);  lit("rel_e1", 4'b0001, 8'hFF);

    // All digits disabled
    bus_a.i_comm = 11'h302;
    do_reset();
    run_to(0);  lit("off_e0",  4'b0000, 8'h00);
    run_to(31); lit("off_e31", 4'b0000, 8'h00);
    run_to(50);

    @(posedge clk);
    #1 armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_driver.md
# display_driver

Multiplexed 7-segment display driver for the alarm-clock front panel. It sits between the clock/menu logic and the LED digit pins. It time-multiplexes SIZE digits of raw 8-bit segment patterns onto one shared segment bus and a one-hot digit-select bus. A packed 11-bit command word applies per-digit enable, per-digit blink and global PWM brightness.

## Interface
Parameters:
- SIZE, 4, number of digits (legal range 1..4).
- TICK, 1, clock cycles per PWM sub-step (≥1).
- BLINK_LOG2, 24, bit index of the free-running cycle counter that sets blink phase.

Ports:
- i_clk  input  1  system clock; one clock domain, all logic on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_comm  input  11  command word:
  - [10:8] brightness B (0..7).
  - [7:4] digit-enable mask; bit d = digit d.
  - [3:0] blink mask; bit d = digit d.
  - Mask bits ≥ SIZE are ignored.
- i_data  input  SIZE*8  segment patterns; byte d = i_data[8d+7:8d] for digit d. Bit 7 = dp, bits 6..0 = g..a. Active-high.
- o_seg  output  8  segment bus, active-high.
- o_dig  output  SIZE  digit select, one-hot or all-zero, active-high.

## Operation
Internal state:
- tick counter t, 0..TICK-1.
- sub-step s, 0..7.
- digit index d, 0..SIZE-1.
- free-running counter c, width BLINK_LOG2+1, wraps.

Counter advance:
- t increments each cycle.
- On t==TICK-1, t→0 and s increments.
- On s 7→0, d increments; d wraps SIZE-1→0.
- Scan order is digit 0, 1, …, SIZE-1, repeat.

Lit condition for the current digit d, evaluated from current state and current inputs every cycle:
- lit = enable[d] AND NOT (blink[d] AND c[BLINK_LOG2]) AND (s ≤ B).

Output update, registered:
- Lit: o_dig ← one-hot(d), o_seg ← byte d of i_data.
- Not lit: o_dig ← 0, o_seg ← 0.
- Outputs are computed from the pre-increment state; the state advances on the same edge.

Input handling:
- Inputs are not latched; any change to i_comm or i_data affects the output on the next rising edge.

Brightness:
- B=7 gives 8/8 duty; B=0 gives 1/8 duty.
- Any digit blanks fully when its enable bit is 0.

## Timing
Reset:
- i_rst_n low clears t, s, d, c and drives o_seg=0 and o_dig=0 immediately, without waiting for a clock edge.
- Reset asserted mid-scan aborts the scan. After release, the scan restarts at digit 0, step 0.

Slot and frame (first rising edge after release is edge 0):
- Edges 0..8·TICK-1 present digit 0 (lit on the steps that satisfy s ≤ B).
- Then digit 1, and so on.
- Frame length is 8·TICK·SIZE cycles.

Latency:
- Input to output: 1 cycle.

Blink:
- Phase toggles every 2^BLINK_LOG2 cycles.
- Blink phase is independent of the scan position.

Boundaries:
- SIZE=1: d is constant 0.
- o_dig never has more than one bit set.

## Test plan
- Full brightness scan: SIZE=4, TICK=1, BLINK_LOG2=24, i_comm=11'h7F0, data0=8'hFF, data1=8'h0F, data2=8'hAA, data3=8'h55; release reset.
  - Edges 0–7: o_dig=4'b0001, o_seg=FF.
  - Edges 8–15: o_dig=0010, o_seg=0F.
  - Edges 16–23: o_dig=0100, o_seg=AA.
  - Edges 24–31: o_dig=1000, o_seg=55.
  - Edge 32: digit 0 again.
- Brightness: i_comm=11'h3F0.
  - Lit on steps 0–3 of each slot; dark (o_dig=0, o_seg=0) on steps 4–7.
  - Same check with B=0: lit on step 0 only.
- Enable mask: i_comm=11'h7A0.
  - Digits 1 and 3 lit with full patterns.
  - Digits 0 and 2 dark for their whole slots.
- Blink: BLINK_LOG2=5, i_comm=11'h7F2.
  - Digit 1 lit while c[5]=0 and dark while c[5]=1.
  - Other digits unaffected.
- Mid-frame input change and reset:
  - Change data0 from FF to 00 during digit 0's slot: o_seg=00 from the next edge.
  - Pulse i_rst_n low mid-slot on digit 2: outputs go 0 immediately.
  - After release: edge 0 shows digit 0, step 0.
- i_comm=11'h302 (all digits disabled): o_dig=0 and o_seg=0 for a full frame.
